// File: rtl/image_load_sequencer.sv
// Sequences the single-block SD reads that load one image into the frame buffer.
// Each block's byte count is policed, and short, long or timed-out blocks are retried.
module image_load_sequencer #(
    parameter logic [31:0] BASE_BLOCK     = 32'h0000_0000,
    parameter logic [31:0] IMG_STRIDE     = 32'h0001_0000,
    parameter int          NUM_IMAGES     = 4,
    parameter int          IMG_BLOCKS     = 450,
    parameter int          BLOCK_BYTES    = 512,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic [3:0]  image_select,
    input  logic        sd_busy,
    input  logic        sd_data_valid,
    output logic [31:0] sd_block_addr,
    output logic        sd_read_block,
    output logic        loading,
    output logic        load_done,
    output logic        load_error,
    output logic        pipe_sync,
    output logic [15:0] blocks_done
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST    = RETRY_W'(MAX_RETRY - 1);
    localparam logic [10:0]        BYTES_EXP     = 11'(BLOCK_BYTES);
    localparam logic [10:0]        BYTE_CNT_MAX  = 11'h7FF;
    localparam logic [15:0]        BLK_LAST      = 16'(IMG_BLOCKS - 1);
    localparam logic [31:0]        NUM_IMAGES_W  = 32'(NUM_IMAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_XFER,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_reg,       state_next;
    logic [31:0]         start_reg,       start_next;
    logic [15:0]         blk_idx_reg,     blk_idx_next;
    logic [RETRY_W-1:0]  retry_reg,       retry_next;
    logic [10:0]         byte_cnt_reg,    byte_cnt_next;
    logic [TIMER_W-1:0]  timer_reg,       timer_next;
    logic                timeout_reg,     timeout_next;
    logic [15:0]         blocks_done_reg, blocks_done_next;
    logic [31:0]         addr_reg,        addr_next;
    logic                read_reg,        read_next;
    logic                done_reg,        done_next;
    logic                error_reg,       error_next;
    logic                sync_reg,        sync_next;

    logic [31:0]         sel_ext;
    logic                sel_valid;
    logic [31:0]         sel_start;

    assign sel_ext   = {28'b0, image_select};
    assign sel_valid = (sel_ext < NUM_IMAGES_W);
    assign sel_start = BASE_BLOCK + sel_ext * IMG_STRIDE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            start_reg       <= '0;
            blk_idx_reg     <= '0;
            retry_reg       <= '0;
            byte_cnt_reg    <= '0;
            timer_reg       <= '0;
            timeout_reg     <= 1'b0;
            blocks_done_reg <= '0;
            addr_reg        <= '0;
            read_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            sync_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            start_reg       <= start_next;
            blk_idx_reg     <= blk_idx_next;
            retry_reg       <= retry_next;
            byte_cnt_reg    <= byte_cnt_next;
            timer_reg       <= timer_next;
            timeout_reg     <= timeout_next;
            blocks_done_reg <= blocks_done_next;
            addr_reg        <= addr_next;
            read_reg        <= read_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            sync_reg        <= sync_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        start_next       = start_reg;
        blk_idx_next     = blk_idx_reg;
        retry_next       = retry_reg;
        byte_cnt_next    = byte_cnt_reg;
        timer_next       = timer_reg;
        timeout_next     = timeout_reg;
        blocks_done_next = blocks_done_reg;
        addr_next        = addr_reg;
        read_next        = 1'b0;
        done_next        = 1'b0;
        error_next       = error_reg;
        sync_next        = 1'b0;

        case (state_reg)
            S_ISSUE: begin
                if (!sd_busy) begin
                    read_next     = 1'b1;
                    addr_next     = start_reg + {16'b0, blk_idx_reg};
                    byte_cnt_next = '0;
                    timer_next    = '0;
                    timeout_next  = 1'b0;
                    state_next    = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY, S_XFER: begin
                if (sd_data_valid && (byte_cnt_reg != BYTE_CNT_MAX)) begin
                    byte_cnt_next = byte_cnt_reg + 11'd1;
                end
                // The attempt's final permitted cycle forces a verdict even mid-transfer.
                if (timer_reg == TIMER_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = S_CHECK;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                    if (state_reg == S_WAIT_BUSY) begin
                        if (sd_busy) begin
                            state_next = S_XFER;
                        end
                    end else if (!sd_busy) begin
                        state_next = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if ((byte_cnt_reg == BYTES_EXP) && !timeout_reg) begin
                    blocks_done_next = blocks_done_reg + 16'd1;
                    retry_next       = '0;
                    if (blk_idx_reg == BLK_LAST) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        blk_idx_next = blk_idx_reg + 16'd1;
                        state_next   = S_ISSUE;
                    end
                end else begin
                    retry_next = retry_reg + RETRY_W'(1);
                    if (retry_reg == RETRY_LAST) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            S_ERROR: begin
                error_next = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A new request wins over everything, including a strobe or done pulse in flight.
        if (load_req) begin
            sync_next        = 1'b1;
            error_next       = 1'b0;
            done_next        = 1'b0;
            read_next        = 1'b0;
            addr_next        = addr_reg;
            blk_idx_next     = '0;
            retry_next       = '0;
            blocks_done_next = '0;
            start_next       = sel_start;
            state_next       = sel_valid ? S_ISSUE : S_ERROR;
        end
    end

    assign sd_block_addr = addr_reg;
    assign sd_read_block = read_reg;
    assign load_done     = done_reg;
    assign load_error    = error_reg;
    assign pipe_sync     = sync_reg;
    assign blocks_done   = blocks_done_reg;
    assign loading       = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERROR);

endmodule

// File: tb/tb_image_load_sequencer.sv
// Self-checking bench for image_load_sequencer: a scripted SD responder plus a
// per-load reference that predicts the read address sequence and outcome.
module tb_image_load_sequencer;

    localparam int          IMG_BLOCKS = 4;
    localparam int          TIMEOUT    = 64;
    localparam int          MAX_RETRY  = 3;
    // A 512-byte block cannot stream inside a 64-cycle attempt, so blocks are scaled to 32 bytes.
    localparam int          BLK_BYTES  = 32;
    localparam int          SHORT_BYTES = BLK_BYTES - 12;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam logic [31:0] STRIDE     = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_req = 1'b0;
    logic [3:0]  image_select = 4'd0;
    logic        sd_busy;
    logic        sd_data_valid;
    logic [31:0] sd_block_addr;
    logic        sd_read_block;
    logic        loading;
    logic        load_done;
    logic        load_error;
    logic        pipe_sync;
    logic [15:0] blocks_done;

    always #5 clk = ~clk;

    image_load_sequencer #(
        .BASE_BLOCK    (BASE),
        .IMG_STRIDE    (STRIDE),
        .NUM_IMAGES    (4),
        .IMG_BLOCKS    (IMG_BLOCKS),
        .BLOCK_BYTES   (BLK_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_req     (load_req),
        .image_select (image_select),
        .sd_busy      (sd_busy),
        .sd_data_valid(sd_data_valid),
        .sd_block_addr(sd_block_addr),
        .sd_read_block(sd_read_block),
        .loading      (loading),
        .load_done    (load_done),
        .load_error   (load_error),
        .pipe_sync    (pipe_sync),
        .blocks_done  (blocks_done)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Monitor log
    int          cyc = 0;
    logic [31:0] strobe_addr_q[$];
    int          strobe_cyc_q[$];
    int          dbl_cnt = 0;
    int          busy_strobe_cnt = 0;
    int          done_cnt = 0;
    int          done_loading_cnt = 0;
    int          psync_cnt = 0;
    logic        prev_strobe = 1'b0;

    // Responder script: byte count per read in order; -1 means never go busy. Empty means a full block.
    int plan_q[$];
    int script_q[$];
    bit model_active = 1'b0;

    // Reference predictions
    logic [31:0] exp_addr_q[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_blocks;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sd_read_block === 1'b1) begin
                strobe_addr_q.push_back(sd_block_addr);
                strobe_cyc_q.push_back(cyc);
                if (prev_strobe === 1'b1) dbl_cnt++;
                if (sd_busy === 1'b1) busy_strobe_cnt++;
            end
            prev_strobe = sd_read_block;
            if (load_done === 1'b1) begin
                done_cnt++;
                if (loading === 1'b1) done_loading_cnt++;
            end
            if (pipe_sync === 1'b1) psync_cnt++;
        end
    end

    // SD responder
    initial begin
        int nbytes;
        int gaps;
        sd_busy = 1'b0;
        sd_data_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sd_read_block === 1'b1) begin
                nbytes = (script_q.size() > 0) ? script_q.pop_front() : BLK_BYTES;
                if (nbytes >= 0) begin
                    model_active = 1'b1;
                    gaps = 0;
                    @(negedge clk);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    sd_busy = 1'b1;
                    for (int i = 0; i < nbytes; i++) begin
                        if (gaps < 8 && $urandom_range(0, 7) == 0) begin
                            sd_data_valid = 1'b0;
                            gaps++;
                            @(negedge clk);
                        end
                        sd_data_valid = 1'b1;
                        @(negedge clk);
                    end
                    sd_data_valid = 1'b0;
                    @(negedge clk);
                    sd_busy = 1'b0;
                    model_active = 1'b0;
                end
            end
        end
    end

    // Walks the block/retry rules over plan_q for one load of image sel.
    task automatic ref_load(input int sel);
        int blk;
        int retry;
        int r;
        int b;
        blk = 0;
        retry = 0;
        r = 0;
        exp_addr_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_blocks = 0;
        while (!exp_done && !exp_err) begin
            exp_addr_q.push_back(BASE + STRIDE * 32'(sel) + 32'(blk));
            b = (r < plan_q.size()) ? plan_q[r] : BLK_BYTES;
            r++;
            if (b == BLK_BYTES) begin
                exp_blocks++;
                blk++;
                retry = 0;
                if (blk == IMG_BLOCKS) exp_done = 1'b1;
            end else begin
                retry++;
                if (retry == MAX_RETRY) exp_err = 1'b1;
            end
        end
    endtask

    task automatic start_load(input logic [3:0] sel, output logic ps, output logic ld, output logic le);
        @(negedge clk);
        image_select = sel;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        ps = pipe_sync;
        ld = loading;
        le = load_error;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((loading === 1'b1 || sd_busy === 1'b1 || model_active) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (n >= budget) $display("FAIL %s_wait: still loading after %0d cycles, required idle", name, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({sd_block_addr, sd_read_block, loading, load_done, load_error, pipe_sync, blocks_done} !== '0)
            $display("FAIL reset_outputs: addr=%0h rd=%0b ld=%0b dn=%0b er=%0b ps=%0b bd=%0d, required all 0",
                     sd_block_addr, sd_read_block, loading, load_done, load_error, pipe_sync, blocks_done);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (strobe_addr_q.size() != 0 || loading !== 1'b0)
            $display("FAIL reset_quiet: strobes=%0d loading=%0b, required 0 and 0", strobe_addr_q.size(), loading);
        else pass_cnt++;
        $display("reset: released, strobes=%0d", strobe_addr_q.size());
    endtask

    task automatic test_nominal();
        logic ps, ld, le;
        int d0;
        plan_q.delete();
        script_q = plan_q;
        ref_load(2);
        strobe_addr_q.delete();
        d0 = done_cnt;
        start_load(4'd2, ps, ld, le);
        total_cnt++;
        if ({ps, ld, le} !== 3'b110)
            $display("FAIL nominal_start: pipe_sync/loading/load_error=%b, required 110", {ps, ld, le});
        else pass_cnt++;
        wait_idle(2000, "nominal");
        total_cnt++;
        if (strobe_addr_q.size() != exp_addr_q.size())
            $display("FAIL nominal_strobes: got %0d, required %0d", strobe_addr_q.size(), exp_addr_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < strobe_addr_q.size(); i++) begin
            total_cnt++;
            if (strobe_addr_q[i] !== exp_addr_q[i])
                $display("FAIL nominal_addr%0d: got %0h, required %0h", i, strobe_addr_q[i], exp_addr_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (blocks_done !== 16'd4) $display("FAIL nominal_blocks: got %0d, required 4", blocks_done);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL nominal_done: got %0d pulses, required 1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (load_error !== 1'b0 || loading !== 1'b0)
            $display("FAIL nominal_end: load_error=%0b loading=%0b, required 0 0", load_error, loading);
        else pass_cnt++;
        total_cnt++;
        if (done_loading_cnt != 0) $display("FAIL done_with_loading: got %0d, required 0", done_loading_cnt);
        else pass_cnt++;
        $display("nominal: image 2, %0d strobes, blocks_done=%0d", strobe_addr_q.size(), blocks_done);
    endtask

    task automatic test_retry();
        logic ps, ld, le;
        plan_q.delete();
        plan_q.push_back(BLK_BYTES);
        plan_q.push_back(SHORT_BYTES);
        script_q = plan_q;
        ref_load(0);
        strobe_addr_q.delete();
        start_load(4'd0, ps, ld, le);
        wait_idle(2000, "retry");
        total_cnt++;
        if (strobe_addr_q.size() != 5) $display("FAIL retry_strobes: got %0d, required 5", strobe_addr_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < strobe_addr_q.size(); i++) begin
            total_cnt++;
            if (strobe_addr_q[i] !== exp_addr_q[i])
                $display("FAIL retry_addr%0d: got %0h, required %0h", i, strobe_addr_q[i], exp_addr_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (blocks_done !== 16'd4 || load_error !== 1'b0)
            $display("FAIL retry_end: blocks_done=%0d load_error=%0b, required 4 0", blocks_done, load_error);
        else pass_cnt++;
        $display("retry: %0d strobes, blocks_done=%0d", strobe_addr_q.size(), blocks_done);
    endtask

    task automatic test_timeout();
        logic ps, ld, le;
        int d0;
        plan_q.delete();
        repeat (3) plan_q.push_back(-1);
        script_q = plan_q;
        strobe_addr_q.delete();
        strobe_cyc_q.delete();
        d0 = done_cnt;
        start_load(4'd0, ps, ld, le);
        wait_idle(1000, "timeout");
        total_cnt++;
        if (strobe_addr_q.size() != 3) $display("FAIL timeout_strobes: got %0d, required 3", strobe_addr_q.size());
        else pass_cnt++;
        for (int i = 0; i < strobe_addr_q.size(); i++) begin
            total_cnt++;
            if (strobe_addr_q[i] !== 32'h0) $display("FAIL timeout_addr%0d: got %0h, required 0", i, strobe_addr_q[i]);
            else pass_cnt++;
        end
        for (int i = 1; i < strobe_cyc_q.size(); i++) begin
            total_cnt++;
            if (strobe_cyc_q[i] - strobe_cyc_q[i-1] < TIMEOUT)
                $display("FAIL timeout_gap%0d: got %0d cycles, required >= %0d", i, strobe_cyc_q[i] - strobe_cyc_q[i-1], TIMEOUT);
            else pass_cnt++;
        end
        total_cnt++;
        if (load_error !== 1'b1 || loading !== 1'b0 || done_cnt != d0)
            $display("FAIL timeout_end: load_error=%0b loading=%0b dones=%0d, required 1 0 0", load_error, loading, done_cnt - d0);
        else pass_cnt++;
        $display("timeout: %0d strobes, load_error=%0b", strobe_addr_q.size(), load_error);
    endtask

    task automatic test_invalid_select();
        logic ps, ld, le;
        int p0;
        strobe_addr_q.delete();
        p0 = psync_cnt;
        start_load(4'd5, ps, ld, le);
        total_cnt++;
        if ({ps, ld, le} !== 3'b100)
            $display("FAIL invalid_start: pipe_sync/loading/load_error=%b, required 100", {ps, ld, le});
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (load_error !== 1'b1) $display("FAIL invalid_error: got %0b, required 1", load_error);
        else pass_cnt++;
        repeat (6) @(posedge clk);
        #1;
        total_cnt++;
        if (strobe_addr_q.size() != 0 || psync_cnt - p0 != 1 || load_error !== 1'b1)
            $display("FAIL invalid_end: strobes=%0d pipe_syncs=%0d load_error=%0b, required 0 1 1",
                     strobe_addr_q.size(), psync_cnt - p0, load_error);
        else pass_cnt++;
        $display("invalid: select 5, load_error=%0b", load_error);
    endtask

    task automatic test_abort();
        logic ps, ld, le;
        int d0, b0, n;
        plan_q.delete();
        script_q = plan_q;
        start_load(4'd0, ps, ld, le);
        n = 0;
        while (!(blocks_done === 16'd2 && sd_busy === 1'b1) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total_cnt++;
        if (n >= 1000) $display("FAIL abort_reach_block2: blocks_done=%0d after %0d cycles, required 2", blocks_done, n);
        else pass_cnt++;
        strobe_addr_q.delete();
        d0 = done_cnt;
        b0 = busy_strobe_cnt;
        ref_load(1);
        start_load(4'd1, ps, ld, le);
        total_cnt++;
        if ({ps, ld} !== 2'b11) $display("FAIL abort_start: pipe_sync/loading=%b, required 11", {ps, ld});
        else pass_cnt++;
        wait_idle(2000, "abort");
        total_cnt++;
        if (strobe_addr_q.size() != exp_addr_q.size())
            $display("FAIL abort_strobes: got %0d, required %0d", strobe_addr_q.size(), exp_addr_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_addr_q.size() && i < strobe_addr_q.size(); i++) begin
            total_cnt++;
            if (strobe_addr_q[i] !== exp_addr_q[i])
                $display("FAIL abort_addr%0d: got %0h, required %0h", i, strobe_addr_q[i], exp_addr_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (busy_strobe_cnt != b0) $display("FAIL abort_busy_strobe: got %0d, required 0", busy_strobe_cnt - b0);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 != 1 || blocks_done !== 16'd4)
            $display("FAIL abort_done: dones=%0d blocks_done=%0d, required 1 4", done_cnt - d0, blocks_done);
        else pass_cnt++;
        $display("abort: restarted on image 1, first addr %0h", (strobe_addr_q.size() > 0) ? strobe_addr_q[0] : 32'hx);
    endtask

    task automatic test_reset_mid_load();
        logic ps, ld, le;
        int n;
        plan_q.delete();
        script_q = plan_q;
        start_load(4'd3, ps, ld, le);
        n = 0;
        while (sd_busy !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({sd_block_addr, sd_read_block, loading, load_done, load_error, pipe_sync, blocks_done} !== '0)
            $display("FAIL midreset_outputs: addr=%0h rd=%0b ld=%0b bd=%0d, required all 0",
                     sd_block_addr, sd_read_block, loading, blocks_done);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        strobe_addr_q.delete();
        repeat (100) @(posedge clk);
        #1;
        total_cnt++;
        if (strobe_addr_q.size() != 0 || loading !== 1'b0)
            $display("FAIL midreset_quiet: strobes=%0d loading=%0b, required 0 0", strobe_addr_q.size(), loading);
        else pass_cnt++;
        $display("reset_mid_load: strobes after release=%0d", strobe_addr_q.size());
    endtask

    task automatic test_random_loads();
        logic ps, ld, le;
        int sel, len, r, d0;
        for (int k = 0; k < 6; k++) begin
            sel = $urandom_range(0, 3);
            len = $urandom_range(0, 5);
            plan_q.delete();
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 7);
                plan_q.push_back((r <= 3) ? BLK_BYTES : (r == 4) ? SHORT_BYTES : (r == 5) ? BLK_BYTES + 1 : (r == 6) ? 0 : -1);
            end
            script_q = plan_q;
            ref_load(sel);
            strobe_addr_q.delete();
            d0 = done_cnt;
            start_load(4'(sel), ps, ld, le);
            total_cnt++;
            if (le !== 1'b0) $display("FAIL rand%0d_error_clear: got %0b, required 0", k, le);
            else pass_cnt++;
            wait_idle(3000, "random");
            total_cnt++;
            if (strobe_addr_q.size() != exp_addr_q.size())
                $display("FAIL rand%0d_strobes: got %0d, required %0d", k, strobe_addr_q.size(), exp_addr_q.size());
            else pass_cnt++;
            for (int i = 0; i < exp_addr_q.size() && i < strobe_addr_q.size(); i++) begin
                total_cnt++;
                if (strobe_addr_q[i] !== exp_addr_q[i])
                    $display("FAIL rand%0d_addr%0d: got %0h, required %0h", k, i, strobe_addr_q[i], exp_addr_q[i]);
                else pass_cnt++;
            end
            total_cnt++;
            if ((done_cnt - d0) != int'(exp_done) || load_error !== exp_err || blocks_done !== 16'(exp_blocks))
                $display("FAIL rand%0d_outcome: done=%0d err=%0b blocks=%0d, required %0d %0b %0d",
                         k, done_cnt - d0, load_error, blocks_done, exp_done, exp_err, exp_blocks);
            else pass_cnt++;
            $display("random load %0d: image %0d, %0d reads planned, %0d strobes, done=%0b err=%0b",
                     k, sel, plan_q.size(), strobe_addr_q.size(), exp_done, exp_err);
        end
    endtask

    task automatic test_strobe_rules();
        total_cnt++;
        if (dbl_cnt != 0) $display("FAIL strobe_back_to_back: got %0d, required 0", dbl_cnt);
        else pass_cnt++;
        total_cnt++;
        if (busy_strobe_cnt != 0) $display("FAIL strobe_while_busy: got %0d, required 0", busy_strobe_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_retry();
        test_timeout();
        test_invalid_select();
        test_abort();
        test_random_loads();
        test_strobe_rules();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
